kcpsmx_intc: RTL and testbench

- Port-mapped interrupt controller sitting between N peripheral interrupt sources and the single interrupt/interrupt_ack pair of the kcpsmx core.
- Latches and prioritises requests, masks them, and drives the core interrupt line through a request/acknowledge/end-of-interrupt state machine.
- Exposes status, mask, mode and active-ID registers on the core's single-cycle port bus (port_id, read_strobe, write_strobe, out_port, in_port).

---
 rtl/kcpsmx_intc_pkg.sv | 32 +++
 rtl/kcpsmx_intc_prio.sv | 24 ++
 rtl/kcpsmx_intc.sv | 152 +++++++++++++++
 tb/tb_kcpsmx_intc.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/kcpsmx_intc_pkg.sv
// Shared types and constants for the kcpsmx port-mapped interrupt controller.
package kcpsmx_intc_pkg;

  localparam int unsigned PORT_WIDTH       = 8;
  localparam int unsigned PORT_DEPTH       = 8;
  localparam int unsigned INTC_MAX_SOURCES = 8;
  localparam int unsigned INTC_ID_W        = 3;

  localparam logic [1:0] INTC_STATUS = 2'd0;
  localparam logic [1:0] INTC_MASK   = 2'd1;
  localparam logic [1:0] INTC_ACTIVE = 2'd2;
  localparam logic [1:0] INTC_MODE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACKED   = 2'd2,
    SERVICE = 2'd3
  } intc_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] sel;
  } intc_decode_t;

  function automatic logic [INTC_MAX_SOURCES-1:0] intc_onehot(
    input logic [INTC_ID_W-1:0] idx
  );
    return INTC_MAX_SOURCES'(1) << idx;
  endfunction

endpackage

// File: rtl/kcpsmx_intc_prio.sv
// Fixed-priority encoder: lowest-index set bit wins.
module kcpsmx_intc_prio
  import kcpsmx_intc_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         eligible_i,
  output logic [INTC_ID_W-1:0] winner_c,
  output logic                 any_valid_c
);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    winner_c    = '0;
    any_valid_c = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        winner_c    = INTC_ID_W'(i);
        any_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kcpsmx_intc.sv
// Interrupt controller between N peripheral sources and the kcpsmx core,
// with a request/ack/EOI handshake and a four-register port-mapped window.
module kcpsmx_intc
  import kcpsmx_intc_pkg::*;
#(
  parameter int unsigned           NUM_SOURCES = 8,
  parameter logic [PORT_DEPTH-1:0] BASE_ADDR   = 8'hE0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_src,
  input  logic [PORT_DEPTH-1:0]  port_id,
  input  logic                   write_strobe,
  input  logic                   read_strobe,
  input  logic [PORT_WIDTH-1:0]  out_port,
  output logic [PORT_WIDTH-1:0]  rd_data,
  output logic                   interrupt,
  input  logic                   interrupt_ack,
  output logic [INTC_ID_W-1:0]   active_id,
  output logic                   busy
);

  intc_state_t                 state_q, state_d;
  logic [NUM_SOURCES-1:0]      pending_q, pending_d;
  logic [NUM_SOURCES-1:0]      mask_q, mask_d;
  logic [NUM_SOURCES-1:0]      mode_q, mode_d;
  logic [NUM_SOURCES-1:0]      src_q;
  logic [INTC_ID_W-1:0]        active_id_q, active_id_d;
  logic                        interrupt_q, interrupt_d;
  logic                        busy_q, busy_d;

  intc_decode_t                dec_c;
  logic [PORT_DEPTH-1:0]       offset_c;
  logic                        wr_status_c, wr_mask_c, wr_mode_c, eoi_c;
  logic [NUM_SOURCES-1:0]      wr_data_c;
  logic [NUM_SOURCES-1:0]      eligible_c;
  logic [INTC_ID_W-1:0]        winner_c;
  logic                        any_valid_c;
  logic                        ack_take_c;
  logic [INTC_MAX_SOURCES-1:0] winner_oh_c;
  logic [NUM_SOURCES-1:0]      ack_clr_c;
  logic [NUM_SOURCES-1:0]      w1c_c;
  logic [NUM_SOURCES-1:0]      edge_set_c;

  // Port window decode; subtraction lets BASE_ADDR sit on any byte.
  always_comb begin
    offset_c    = port_id - BASE_ADDR;
    dec_c.hit   = (offset_c < PORT_DEPTH'(4));
    dec_c.sel   = offset_c[1:0];
    wr_data_c   = out_port[NUM_SOURCES-1:0];
    wr_status_c = write_strobe && dec_c.hit && (dec_c.sel == INTC_STATUS);
    wr_mask_c   = write_strobe && dec_c.hit && (dec_c.sel == INTC_MASK);
    eoi_c       = write_strobe && dec_c.hit && (dec_c.sel == INTC_ACTIVE);
    wr_mode_c   = write_strobe && dec_c.hit && (dec_c.sel == INTC_MODE);
  end

  assign eligible_c = pending_q & mask_q;

  kcpsmx_intc_prio #(
    .N (NUM_SOURCES)
  ) u_prio (
    .eligible_i  (eligible_c),
    .winner_c    (winner_c),
    .any_valid_c (any_valid_c)
  );

  // Next-state: handshake FSM, pending/mask/mode registers, registered outputs.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    mask_d      = mask_q;
    mode_d      = mode_q;
    ack_take_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_valid_c) state_d = REQ;
      end
      REQ: begin
        if (!any_valid_c) begin
          state_d = IDLE;
        end else if (interrupt_ack) begin
          state_d     = ACKED;
          active_id_d = winner_c;
          ack_take_c  = 1'b1;
        end
      end
      ACKED: begin
        state_d = eoi_c ? IDLE : SERVICE;
      end
      SERVICE: begin
        if (eoi_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    winner_oh_c = intc_onehot(winner_c);
    ack_clr_c   = ack_take_c ? winner_oh_c[NUM_SOURCES-1:0] : '0;
    w1c_c       = wr_status_c ? wr_data_c : '0;
    edge_set_c  = irq_src & ~src_q;
    // Edge bits: a new edge beats a same-cycle clear. Level bits mirror the source.
    pending_d   = (mode_q & (edge_set_c | (pending_q & ~w1c_c & ~ack_clr_c)))
                | (~mode_q & irq_src);

    if (wr_mask_c) mask_d = wr_data_c;
    if (wr_mode_c) mode_d = wr_data_c;

    interrupt_d = (state_d == REQ);
    busy_d      = (state_d == ACKED) || (state_d == SERVICE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      mask_q      <= '0;
      mode_q      <= '0;
      src_q       <= '0;
      active_id_q <= '0;
      interrupt_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      src_q       <= irq_src;
      active_id_q <= active_id_d;
      interrupt_q <= interrupt_d;
      busy_q      <= busy_d;
    end
  end

  // Side-effect-free read mux; zero unless a read hits the window.
  always_comb begin
    rd_data = '0;
    if (read_strobe && dec_c.hit) begin
      unique case (dec_c.sel)
        INTC_STATUS: rd_data = PORT_WIDTH'(pending_q);
        INTC_MASK:   rd_data = PORT_WIDTH'(mask_q);
        INTC_ACTIVE: rd_data = PORT_WIDTH'(active_id_q);
        INTC_MODE:   rd_data = PORT_WIDTH'(mode_q);
        default:     rd_data = '0;
      endcase
    end
  end

  assign interrupt = interrupt_q;
  assign busy      = busy_q;
  assign active_id = active_id_q;

endmodule

// File: tb/tb_kcpsmx_intc.sv
// Directed self-checking bench for kcpsmx_intc.
module tb_kcpsmx_intc;
  import kcpsmx_intc_pkg::*;

  localparam logic [7:0] BASE = 8'hE0;

  logic       clk;
  logic       reset;
  logic [7:0] irq_src;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] rd_data;
  logic       interrupt;
  logic       interrupt_ack;
  logic [2:0] active_id;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  kcpsmx_intc #(
    .NUM_SOURCES (8),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_src       (irq_src),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .out_port      (out_port),
    .rd_data       (rd_data),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .active_id     (active_id),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one edge and park mid-cycle on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    port_id      = BASE + {6'b0, off};
    out_port     = d;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    out_port     = 8'h00;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    port_id     = addr;
    read_strobe = 1'b1;
    #1;
    chk(tag, rd_data, exp);
    read_strobe = 1'b0;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq_src = 8'h00; port_id = 8'h00; write_strobe = 1'b0;
    read_strobe = 1'b0; out_port = 8'h00; interrupt_ack = 1'b0;
    repeat (2) tick();
    chk("rst_int", {7'b0, interrupt}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_id", {5'b0, active_id}, 8'h00);
    reset = 1'b1;
    tick();

    // Edge request on source 4.
    wr(INTC_MODE, 8'hFF);
    wr(INTC_MASK, 8'h10);
    irq_src = 8'h10; tick(); irq_src = 8'h00;
    rd_chk("edge_status", BASE, 8'h10);
    chk("edge_int_lat0", {7'b0, interrupt}, 8'h00);
    tick();
    chk("edge_int_lat1", {7'b0, interrupt}, 8'h01);
    ack();
    chk("edge_ack_id", {5'b0, active_id}, 8'h04);
    chk("edge_ack_int", {7'b0, interrupt}, 8'h00);
    chk("edge_ack_busy", {7'b0, busy}, 8'h01);
    rd_chk("edge_ack_status", BASE, 8'h00);
    rd_chk("edge_active_rd", BASE + 8'd2, 8'h04);
    tick();
    chk("service_busy", {7'b0, busy}, 8'h01);
    wr(INTC_ACTIVE, 8'h00);
    chk("eoi_busy", {7'b0, busy}, 8'h00);

    // Priority between sources 1 and 3.
    wr(INTC_MASK, 8'hFF);
    irq_src = 8'h0A; tick(); irq_src = 8'h00;
    tick();
    chk("prio_int", {7'b0, interrupt}, 8'h01);
    ack();
    chk("prio_id1", {5'b0, active_id}, 8'h01);
    rd_chk("prio_status", BASE, 8'h08);
    tick();
    wr(INTC_ACTIVE, 8'h00);
    tick();
    chk("prio_int2", {7'b0, interrupt}, 8'h01);
    ack();
    chk("prio_id3", {5'b0, active_id}, 8'h03);
    rd_chk("prio_status2", BASE, 8'h00);
    wr(INTC_ACTIVE, 8'h00);

    // Masking.
    wr(INTC_MASK, 8'h00);
    irq_src = 8'h04; tick(); irq_src = 8'h00;
    tick(); tick();
    chk("masked_int", {7'b0, interrupt}, 8'h00);
    rd_chk("masked_status", BASE, 8'h04);
    wr(INTC_MASK, 8'h04);
    chk("mask_wr_edge", {7'b0, interrupt}, 8'h00);
    tick();
    chk("mask_int_rise", {7'b0, interrupt}, 8'h01);
    wr(INTC_MASK, 8'h00);
    tick();
    chk("mask_drop_int", {7'b0, interrupt}, 8'h00);
    chk("mask_drop_busy", {7'b0, busy}, 8'h00);
    wr(INTC_STATUS, 8'h04);
    rd_chk("w1c_clear", BASE, 8'h00);

    // Level mode on source 0.
    wr(INTC_MODE, 8'h00);
    wr(INTC_MASK, 8'h01);
    irq_src = 8'h01; tick(); tick();
    chk("lvl_int", {7'b0, interrupt}, 8'h01);
    ack();
    chk("lvl_id", {5'b0, active_id}, 8'h00);
    rd_chk("lvl_status_ack", BASE, 8'h01);
    wr(INTC_STATUS, 8'h01);
    rd_chk("lvl_w1c_ignored", BASE, 8'h01);
    wr(INTC_ACTIVE, 8'h00);
    tick();
    chk("lvl_reassert", {7'b0, interrupt}, 8'h01);
    irq_src = 8'h00; tick();
    rd_chk("lvl_status_drop", BASE, 8'h00);
    tick();
    chk("lvl_int_drop", {7'b0, interrupt}, 8'h00);

    // Set/clear contention, decode boundaries, stray ack.
    wr(INTC_MODE, 8'hFF);
    irq_src = 8'h04;
    wr(INTC_STATUS, 8'h04);
    irq_src = 8'h00;
    rd_chk("set_beats_w1c", BASE, 8'h04);
    wr(INTC_STATUS, 8'h04);
    rd_chk("w1c_alone", BASE, 8'h00);
    rd_chk("mode_rd", BASE + 8'd3, 8'hFF);
    rd_chk("mask_rd", BASE + 8'd1, 8'h01);
    rd_chk("out_of_window", BASE + 8'd4, 8'h00);
    port_id = BASE + 8'd3; read_strobe = 1'b0; #1;
    chk("no_strobe", rd_data, 8'h00);
    ack();
    chk("stray_ack_busy", {7'b0, busy}, 8'h00);

    // Asynchronous reset in the middle of a request.
    wr(INTC_MASK, 8'hFF);
    irq_src = 8'h05; tick(); irq_src = 8'h00;
    tick();
    chk("pre_rst_int", {7'b0, interrupt}, 8'h01);
    reset = 1'b0; #1;
    chk("async_rst_int", {7'b0, interrupt}, 8'h00);
    chk("async_rst_busy", {7'b0, busy}, 8'h00);
    rd_chk("async_rst_status", BASE, 8'h00);
    rd_chk("async_rst_mask", BASE + 8'd1, 8'h00);
    reset = 1'b1;
    tick(); tick();
    chk("post_rst_int", {7'b0, interrupt}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
